// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared constants for the multi-cycle MIPS control unit:
//   - instruction opcode / funct encodings
//   - 5-bit ALUOp codes consumed by the ALU control decoder
//   - FSM state encodings (4-bit, visible on state_o)
//   - datapath mux select codes (pc_src, alu_src_b, reg_dst, mem_to_reg)
//   - ctrlSignals_t, the bundle of datapath controls produced each cycle
//   - immAluOp(), the ALUOp for immediate-format ALU instructions
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   // funct (IR[5:0]) values the sequencer itself cares about
   localparam logic [5:0] FUNCT_JR = 6'b001000;

   // ALUOp codes
   localparam logic [4:0] ALUOP_R    = 5'b00000;
   localparam logic [4:0] ALUOP_ADDI = 5'b00001;
   localparam logic [4:0] ALUOP_ANDI = 5'b00010;
   localparam logic [4:0] ALUOP_ORI  = 5'b00011;
   localparam logic [4:0] ALUOP_LUI  = 5'b00100;
   localparam logic [4:0] ALUOP_LW   = 5'b00101;
   localparam logic [4:0] ALUOP_SW   = 5'b00110;
   localparam logic [4:0] ALUOP_BEQ  = 5'b00111;
   localparam logic [4:0] ALUOP_BNE  = 5'b01001;
   // Plain address add (PC+4, branch target) reuses the ADDI code
   localparam logic [4:0] ALUOP_ADD  = ALUOP_ADDI;

   // FSM state encodings
   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXEC   = 4'd2;
   localparam logic [3:0] S_ALU_WB = 4'd3;
   localparam logic [3:0] S_ADDR   = 4'd4;
   localparam logic [3:0] S_MEM    = 4'd5;
   localparam logic [3:0] S_MEM_WB = 4'd6;
   localparam logic [3:0] S_BRANCH = 4'd7;
   localparam logic [3:0] S_JUMP   = 4'd8;

   // pc_src selects
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_RS     = 2'd3;

   // alu_src_b selects
   localparam logic [1:0] SRCB_B       = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   // reg_dst selects
   localparam logic [1:0] DST_RT  = 2'd0;
   localparam logic [1:0] DST_RD  = 2'd1;
   localparam logic [1:0] DST_R31 = 2'd2;

   // mem_to_reg selects
   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;

   typedef struct packed {
      logic       memReq;
      logic       memWrite;
      logic       iOrD;
      logic       irWrite;
      logic       pcWrite;
      logic [1:0] pcSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [4:0] aluOp;
      logic       regWrite;
      logic [1:0] regDst;
      logic [1:0] memToReg;
      logic       illegalOp;
   } ctrlSignals_t;

   // ALUOp for the immediate-format ALU instructions handled in EXEC
   function automatic logic [4:0] immAluOp(input logic [5:0] op);
      case (op)
         OP_ANDI: immAluOp = ALUOP_ANDI;
         OP_ORI:  immAluOp = ALUOP_ORI;
         OP_LUI:  immAluOp = ALUOP_LUI;
         default: immAluOp = ALUOP_ADDI;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_watchdog.sv
// ---------------------------------------------------------------------------
// mem_watchdog
//   Counts cycles a memory request has been outstanding without an ack and
//   flags a timeout on the cycle the count reaches MEM_TIMEOUT-1.
//   MEM_TIMEOUT = 0 disables the timeout (wait forever).
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   clear    in   zero the count (takes priority over counting)
//   active   in   a memory request is being driven this cycle
//   ack      in   memory acknowledges this cycle
//   timeout  out  combinational: request expires this cycle
// ---------------------------------------------------------------------------
module mem_watchdog #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic active,
   input  logic ack,
   output logic timeout
);

   localparam logic [TMO_W-1:0] LIMIT =
      (MEM_TIMEOUT == 0) ? '0 : TMO_W'(MEM_TIMEOUT - 1);

   logic [TMO_W-1:0] countReg;
   logic             waiting;

   assign waiting = active && !ack;

   // An ack in the final cycle masks the timeout because waiting drops.
   assign timeout = (MEM_TIMEOUT != 0) && waiting && (countReg == LIMIT);

   // Saturate rather than wrap so a disabled watchdog never aliases.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         countReg <= '0;
      end else if (clear) begin
         countReg <= '0;
      end else if (waiting && (countReg != '1)) begin
         countReg <= countReg + TMO_W'(1);
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//   Main sequencer for the multi-cycle MIPS datapath. Walks each instruction
//   through FETCH/DECODE/EXEC/MEM/WB, drives the datapath selects and write
//   enables, produces the 5-bit ALUOp, runs the memory req/ack handshake and
//   aborts a stalled access through a watchdog.
// Ports
//   clk, reset (async active-low)
//   opcode, funct   IR fields       zero     ALU zero flag
//   mem_ack         memory done     mem_req/mem_write/i_or_d  memory control
//   ir_write, pc_write, pc_src      IR / PC update
//   alu_src_a, alu_src_b, alu_op    ALU operand and operation selects
//   reg_write, reg_dst, mem_to_reg  register-file writeback
//   illegal_op, mem_err             one-cycle error pulses
//   state_o                         current state (debug)
// ---------------------------------------------------------------------------
module multicycle_control_unit
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TMO_W       = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [4:0] alu_op,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state_o
);

   logic [3:0]   stateReg;
   logic [3:0]   stateNext;
   ctrlSignals_t ctrl;
   ctrlSignals_t ctrlOut;
   logic         memActive;
   logic         timeout;
   logic         wdClear;
   logic         isRType;

   assign isRType   = (opcode == OP_RTYPE);
   assign memActive = (stateReg == S_FETCH) || (stateReg == S_MEM);

   // Restart the count whenever a fresh request window opens, including
   // the refetch that follows a timeout in FETCH.
   assign wdClear = ((stateNext == S_FETCH) || (stateNext == S_MEM)) &&
                    ((stateNext != stateReg) || timeout);

   mem_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TMO_W       (TMO_W)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wdClear),
      .active  (memActive),
      .ack     (mem_ack),
      .timeout (timeout)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateReg <= S_FETCH;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      ctrl      = '0;
      stateNext = S_FETCH;
      case (stateReg)
         S_FETCH: begin
            ctrl.memReq  = 1'b1;
            ctrl.aluSrcB = SRCB_FOUR;
            ctrl.aluOp   = ALUOP_ADD;
            if (mem_ack) begin
               ctrl.irWrite = 1'b1;
               ctrl.pcWrite = 1'b1;
               ctrl.pcSrc   = PCSRC_ALU;
               stateNext    = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculatively compute the branch target into ALUOut.
            ctrl.aluSrcB = SRCB_IMM_SH2;
            ctrl.aluOp   = ALUOP_ADD;
            case (opcode)
               OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: stateNext = S_EXEC;
               OP_LW, OP_SW:                               stateNext = S_ADDR;
               OP_BEQ, OP_BNE:                             stateNext = S_BRANCH;
               OP_J, OP_JAL:                               stateNext = S_JUMP;
               default: begin
                  ctrl.illegalOp = 1'b1;
                  stateNext      = S_FETCH;
               end
            endcase
         end
         S_EXEC: begin
            ctrl.aluSrcA = 1'b1;
            if (isRType) begin
               ctrl.aluSrcB = SRCB_B;
               ctrl.aluOp   = ALUOP_R;
               if (funct == FUNCT_JR) begin
                  // JR retires here: PC <= rs, no register writeback.
                  ctrl.pcWrite = 1'b1;
                  ctrl.pcSrc   = PCSRC_RS;
                  stateNext    = S_FETCH;
               end else begin
                  stateNext = S_ALU_WB;
               end
            end else begin
               ctrl.aluSrcB = SRCB_IMM;
               ctrl.aluOp   = immAluOp(opcode);
               stateNext    = S_ALU_WB;
            end
         end
         S_ALU_WB: begin
            ctrl.regWrite = 1'b1;
            ctrl.regDst   = isRType ? DST_RD : DST_RT;
            ctrl.memToReg = WB_ALUOUT;
         end
         S_ADDR: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = (opcode == OP_SW) ? ALUOP_SW : ALUOP_LW;
            stateNext    = S_MEM;
         end
         S_MEM: begin
            ctrl.memReq   = 1'b1;
            ctrl.iOrD     = 1'b1;
            ctrl.memWrite = (opcode == OP_SW);
            if (mem_ack) begin
               stateNext = (opcode == OP_LW) ? S_MEM_WB : S_FETCH;
            end else if (timeout) begin
               stateNext = S_FETCH;
            end else begin
               stateNext = S_MEM;
            end
         end
         S_MEM_WB: begin
            ctrl.regWrite = 1'b1;
            ctrl.regDst   = DST_RT;
            ctrl.memToReg = WB_MDR;
         end
         S_BRANCH: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_B;
            ctrl.pcSrc   = PCSRC_ALUOUT;
            if (opcode == OP_BNE) begin
               ctrl.aluOp   = ALUOP_BNE;
               ctrl.pcWrite = !zero;
            end else begin
               ctrl.aluOp   = ALUOP_BEQ;
               ctrl.pcWrite = zero;
            end
         end
         S_JUMP: begin
            ctrl.pcWrite = 1'b1;
            ctrl.pcSrc   = PCSRC_JUMP;
            if (opcode == OP_JAL) begin
               // PC already holds the return address (+4 applied in FETCH).
               ctrl.regWrite = 1'b1;
               ctrl.regDst   = DST_R31;
               ctrl.memToReg = WB_PC;
            end
         end
         default: stateNext = S_FETCH;
      endcase
   end

   // While reset is held the datapath sees only the pending fetch request,
   // so a stray ack or a late edge cannot trigger any write.
   always_comb begin
      ctrlOut        = '0;
      ctrlOut.memReq = 1'b1;
      if (reset) begin
         ctrlOut = ctrl;
      end
   end

   assign mem_req    = ctrlOut.memReq;
   assign mem_write  = ctrlOut.memWrite;
   assign i_or_d     = ctrlOut.iOrD;
   assign ir_write   = ctrlOut.irWrite;
   assign pc_write   = ctrlOut.pcWrite;
   assign pc_src     = ctrlOut.pcSrc;
   assign alu_src_a  = ctrlOut.aluSrcA;
   assign alu_src_b  = ctrlOut.aluSrcB;
   assign alu_op     = ctrlOut.aluOp;
   assign reg_write  = ctrlOut.regWrite;
   assign reg_dst    = ctrlOut.regDst;
   assign mem_to_reg = ctrlOut.memToReg;
   assign illegal_op = ctrlOut.illegalOp;
   assign mem_err    = reset && timeout;
   assign state_o    = stateReg;

endmodule
